// File: rtl/wb_scheduler_pkg.sv
// Shared definitions for the writeback scheduler: FSM states, select codes
// and a helper for index widths.
package wb_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [3:0] SEL_ALU = 4'b0000;
  localparam logic [3:0] SEL_MEM = 4'b0001;
  localparam logic [3:0] SEL_MAX = 4'b1000;

  // Width of a requester index; never zero so a single requester still works.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_scheduler_rr_arbiter.sv
// Combinational round-robin pick: searches upward from i_ptr (wrapping) for
// the first unmasked request and reports whether one exists and its index.
module rr_arbiter
  import wb_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  logic [NREQ-1:0] w_cand;

  assign w_cand = i_req & ~i_mask;

  // First candidate in ascending modular order starting at the pointer wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_valid && w_cand[IW'(j)]) begin
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin arbitration among writeback requesters,
// one register-file write per cycle, with an extra WAIT cycle for memory
// loads whose data arrives one cycle after grant.
//
// Handshake: a requester holds req high (with stable req_sel/req_rd) until it
// sees its one-cycle grant pulse; grant marks the cycle its write happens.
// A flush suppresses the pending write and the requester keeps requesting.
module wb_scheduler
  import wb_scheduler_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter logic [3:0] MEM_SEL = SEL_MEM
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_sel,
  input  logic [5*NREQ-1:0] req_rd,
  input  logic              flush,
  output logic [NREQ-1:0]   grant,
  output logic [3:0]        mem_to_reg,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic              busy,
  output logic              sel_err,
  output state_t            state_dbg
);

  localparam int              IW  = idx_width(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [3:0]      r_sel;
  logic [4:0]      r_rd;

  logic [NREQ-1:0] w_mask;
  logic            w_valid;
  logic [IW-1:0]   w_idx;
  logic [3:0]      w_win_sel;
  logic [4:0]      w_win_rd;
  logic            w_latch;
  logic            w_write;

  // The requester being written this cycle still holds req; hide it so the
  // next winner can be latched back-to-back.
  assign w_mask = (r_state == WRITE) ? (ONE << r_idx) : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req   (req),
    .i_mask  (w_mask),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_win_sel = req_sel[4*w_idx +: 4];
  assign w_win_rd  = req_rd[5*w_idx +: 5];
  assign w_latch   = w_valid && !flush && ((r_state == IDLE) || (r_state == WRITE));

  // Next-state decode: arbitration is open in IDLE and WRITE only.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, WRITE: begin
        if (w_latch) w_next = (w_win_sel == MEM_SEL) ? WAIT : WRITE;
        else         w_next = IDLE;
      end
      WAIT:    w_next = flush ? IDLE : WRITE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus capture of the winning request and pointer advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_idx <= w_idx;
        r_sel <= w_win_sel;
        r_rd  <= w_win_rd;
        r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  assign w_write = (r_state == WRITE) && !flush;

  // Output decode from state and captured fields; flush only suppresses.
  always_comb begin
    grant      = '0;
    mem_to_reg = '0;
    reg_write  = 1'b0;
    write_reg  = '0;
    sel_err    = 1'b0;
    if (w_write) begin
      grant     = ONE << r_idx;
      write_reg = r_rd;
      if (r_sel > SEL_MAX) begin
        sel_err = 1'b1;
      end else begin
        mem_to_reg = r_sel;
        reg_write  = (r_rd != 5'd0);
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_wb_scheduler.sv
// Bench for wb_scheduler: directed cycle table, reset corner case and a
// randomized run against a transaction-level schedule model.
module tb_wb_scheduler;
  import wb_scheduler_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [4*N-1:0] req_sel;
  logic [5*N-1:0] req_rd;
  logic          flush;
  logic [N-1:0]  grant;
  logic [3:0]    mem_to_reg;
  logic          reg_write;
  logic [4:0]    write_reg;
  logic          busy;
  logic          sel_err;
  state_t        state_dbg;

  int checks = 0;
  int errors = 0;

  // Clock / reset generation
  always #5 clk = ~clk;

  wb_scheduler #(.NREQ(N), .MEM_SEL(SEL_MEM)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_sel    (req_sel),
    .req_rd     (req_rd),
    .flush      (flush),
    .grant      (grant),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .busy       (busy),
    .sel_err    (sel_err),
    .state_dbg  (state_dbg)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] sel;
    logic [19:0] rd;
    logic        flush;
    logic [3:0]  g;
    logic        rw;
    logic [4:0]  wr;
    logic [3:0]  m;
    logic        b;
    logic        e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic rw,
                           input logic [4:0] wr, input logic [3:0] m,
                           input logic b, input logic e);
    chk({tag, ".grant"},      32'(grant),      32'(g));
    chk({tag, ".reg_write"},  32'(reg_write),  32'(rw));
    chk({tag, ".write_reg"},  32'(write_reg),  32'(wr));
    chk({tag, ".mem_to_reg"}, 32'(mem_to_reg), 32'(m));
    chk({tag, ".busy"},       32'(busy),       32'(b));
    chk({tag, ".sel_err"},    32'(sel_err),    32'(e));
  endtask

  task automatic add(input logic [3:0] rq, input logic [15:0] s, input logic [19:0] r,
                     input logic f, input logic [3:0] g, input logic rw,
                     input logic [4:0] wr, input logic [3:0] m, input logic b,
                     input logic e);
    vec_t v;
    v.req = rq; v.sel = s; v.rd = r; v.flush = f;
    v.g = g; v.rw = rw; v.wr = wr; v.m = m; v.b = b; v.e = e;
    tbl.push_back(v);
  endtask

  function automatic logic [19:0] rds(input logic [4:0] a3, input logic [4:0] a2,
                                      input logic [4:0] a1, input logic [4:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  // Driver: apply one cycle's inputs just after the rising edge.
  task automatic drive(input logic [3:0] rq, input logic [15:0] s, input logic [19:0] r,
                       input logic f);
    req = rq; req_sel = s; req_rd = r; flush = f;
  endtask

  // Schedule model: a latched request becomes a write due 1 or 2 cycles later.
  bit         m_pend;
  int         m_idx;
  logic [3:0] m_sel;
  logic [4:0] m_rd;
  int         m_due;
  int         m_ptr;
  int         cyc;

  task automatic model_reset();
    m_pend = 0; m_idx = 0; m_sel = '0; m_rd = '0; m_due = 0; m_ptr = 0; cyc = 0;
  endtask

  task automatic model_expect(output logic [3:0] g, output logic rw, output logic [4:0] wr,
                              output logic [3:0] m, output logic b, output logic e);
    bit writing;
    writing = m_pend && (m_due == cyc) && !flush;
    g = '0; rw = 0; wr = '0; m = '0; e = 0;
    b = m_pend;
    if (writing) begin
      g  = 4'(1 << m_idx);
      wr = m_rd;
      if (m_sel > 4'd8) e = 1;
      else begin
        m  = m_sel;
        rw = (m_rd != 0);
      end
    end
  endtask

  task automatic model_step();
    bit open;
    int masked;
    int win;
    open   = !flush && (!m_pend || m_due == cyc);
    masked = (m_pend && m_due == cyc) ? m_idx : -1;
    win    = -1;
    if (open) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && req[j] && j != masked) win = j;
      end
    end
    if (win >= 0) begin
      m_pend = 1;
      m_idx  = win;
      m_sel  = req_sel[4*win +: 4];
      m_rd   = req_rd[5*win +: 5];
      m_due  = cyc + ((m_sel == SEL_MEM) ? 2 : 1);
      m_ptr  = (win + 1) % N;
    end else if (flush || (m_pend && m_due == cyc)) begin
      m_pend = 0;
    end
    cyc++;
  endtask

  initial begin
    logic [3:0] sel_pool [7];
    logic [3:0] eg, em, last_g;
    logic       erw, eb, ee;
    logic [4:0] ewr;
    logic [19:0] r1;

    sel_pool = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd8, 4'd9, 4'd15};
    r1 = rds(5'd4, 5'd3, 5'd2, 5'd1);

    // Round-robin over all four, held requests, no gaps
    add(4'b1111, 16'h0000, r1, 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b1111, 16'h0000, r1, 0, 4'b0001, 1, 5'd1, 4'd0, 1, 0);
    add(4'b1111, 16'h0000, r1, 0, 4'b0010, 1, 5'd2, 4'd0, 1, 0);
    add(4'b1111, 16'h0000, r1, 0, 4'b0100, 1, 5'd3, 4'd0, 1, 0);
    add(4'b1111, 16'h0000, r1, 0, 4'b1000, 1, 5'd4, 4'd0, 1, 0);
    add(4'b0000, 16'h0000, r1, 0, 4'b0001, 1, 5'd1, 4'd0, 1, 0);
    add(4'b0000, 16'h0000, r1, 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // Single ALU write from requester 1, rd 8; pointer moves to 2
    add(4'b0010, 16'h0000, rds(0, 0, 8, 0), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b0010, 16'h0000, rds(0, 0, 8, 0), 0, 4'b0010, 1, 5'd8, 4'd0, 1, 0);
    add(4'b0000, 16'h0000, rds(0, 0, 8, 0), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // Pointer at 2: requester 3 first, then 0, then 1
    add(4'b1011, 16'h0000, r1, 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b1011, 16'h0000, r1, 0, 4'b1000, 1, 5'd4, 4'd0, 1, 0);
    add(4'b0011, 16'h0000, r1, 0, 4'b0001, 1, 5'd1, 4'd0, 1, 0);
    add(4'b0010, 16'h0000, r1, 0, 4'b0010, 1, 5'd2, 4'd0, 1, 0);
    add(4'b0000, 16'h0000, r1, 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // Memory load from requester 0: one WAIT cycle then write
    add(4'b0001, 16'h0001, rds(0, 0, 0, 5), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b0001, 16'h0001, rds(0, 0, 0, 5), 0, 4'b0000, 0, 5'd0, 4'd0, 1, 0);
    add(4'b0001, 16'h0001, rds(0, 0, 0, 5), 0, 4'b0001, 1, 5'd5, 4'd1, 1, 0);
    add(4'b0000, 16'h0001, rds(0, 0, 0, 5), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // Flush during WAIT, pointer kept at 3, then ALU write followed by WAIT
    add(4'b0100, 16'h0100, rds(0, 7, 0, 9), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b0100, 16'h0100, rds(0, 7, 0, 9), 1, 4'b0000, 0, 5'd0, 4'd0, 1, 0);
    add(4'b0101, 16'h0100, rds(0, 7, 0, 9), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b0101, 16'h0100, rds(0, 7, 0, 9), 0, 4'b0001, 1, 5'd9, 4'd0, 1, 0);
    add(4'b0100, 16'h0100, rds(0, 7, 0, 9), 0, 4'b0000, 0, 5'd0, 4'd0, 1, 0);
    add(4'b0100, 16'h0100, rds(0, 7, 0, 9), 0, 4'b0100, 1, 5'd7, 4'd1, 1, 0);
    add(4'b0000, 16'h0100, rds(0, 7, 0, 9), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // Flush during WRITE suppresses the write; request retried
    add(4'b1000, 16'h0000, rds(6, 0, 0, 0), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b1000, 16'h0000, rds(6, 0, 0, 0), 1, 4'b0000, 0, 5'd0, 4'd0, 1, 0);
    add(4'b1000, 16'h0000, rds(6, 0, 0, 0), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b1000, 16'h0000, rds(6, 0, 0, 0), 0, 4'b1000, 1, 5'd6, 4'd0, 1, 0);
    add(4'b0000, 16'h0000, rds(6, 0, 0, 0), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // Flush in IDLE blocks latching
    add(4'b0001, 16'h0000, rds(0, 0, 0, 3), 1, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b0001, 16'h0000, rds(0, 0, 0, 3), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    add(4'b0001, 16'h0000, rds(0, 0, 0, 3), 0, 4'b0001, 1, 5'd3, 4'd0, 1, 0);
    add(4'b0000, 16'h0000, rds(0, 0, 0, 3), 0, 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    // rd 0 (no write), illegal sel 1010 (sel_err), boundary sel 1000
    add(4'b0010, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0000, 0, 5'd0,  4'd0, 0, 0);
    add(4'b0010, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0010, 0, 5'd0,  4'd0, 1, 0);
    add(4'b0100, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0000, 0, 5'd0,  4'd0, 0, 0);
    add(4'b0100, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0100, 0, 5'd12, 4'd0, 1, 1);
    add(4'b0001, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0000, 0, 5'd0,  4'd0, 0, 0);
    add(4'b0001, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0001, 1, 5'd2,  4'd8, 1, 0);
    add(4'b0000, 16'h0A08, rds(0, 12, 0, 2), 0, 4'b0000, 0, 5'd0,  4'd0, 0, 0);

    // Reset
    reset_n = 1'b0;
    drive(4'b0000, 16'h0000, 20'h0, 1'b0);
    #12;
    check_all("reset", 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    chk("reset.state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1 reset_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].req, tbl[i].sel, tbl[i].rd, tbl[i].flush);
      @(negedge clk);
      check_all($sformatf("row%0d", i), tbl[i].g, tbl[i].rw, tbl[i].wr, tbl[i].m,
                tbl[i].b, tbl[i].e);
    end

    // Reset asserted in the middle of a WAIT cycle
    @(posedge clk); #1;
    drive(4'b0010, 16'h0010, rds(0, 0, 5, 0), 1'b0);
    @(posedge clk); #2;
    chk("midwait.busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all("midwait_rst", 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    @(posedge clk); #1 drive(4'b0000, 16'h0000, 20'h0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_all($sformatf("post_rst%0d", c), 4'b0000, 0, 5'd0, 4'd0, 0, 0);
    end

    // Randomized run against the schedule model
    model_reset();
    last_g = '0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_g[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_sel[4*i +: 4] = sel_pool[$urandom_range(0, 6)];
          req_rd[5*i +: 5]  = 5'($urandom_range(0, 31));
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      model_expect(eg, erw, ewr, em, eb, ee);
      check_all($sformatf("rand%0d", c), eg, erw, ewr, em, eb, ee);
      last_g = eg;
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
